cmp_sort_ctrl: RTL



---
 rtl/cmp_sort_if.sv | 39 +++
 rtl/cmp_sort_ctrl.sv | 133 +++++++++++++
 2 files changed

// File: rtl/cmp_sort_if.sv
// Handshake/bus bundle for cmp_sort_ctrl: write port, start, read port and status.
// Optional statistics outputs exist only when SORT_STATS_EN is defined.
interface cmp_sort_if #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 4
);
  localparam int unsigned AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;

  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             start;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic             busy;
  logic             done;
`ifdef SORT_STATS_EN
  logic [7:0]       cmp_cnt;
  logic [7:0]       swap_cnt;

  modport master (
    output wr_en, wr_addr, wr_data, start, rd_addr,
    input  rd_data, busy, done, cmp_cnt, swap_cnt
  );
  modport slave (
    input  wr_en, wr_addr, wr_data, start, rd_addr,
    output rd_data, busy, done, cmp_cnt, swap_cnt
  );
`else
  modport master (
    output wr_en, wr_addr, wr_data, start, rd_addr,
    input  rd_data, busy, done
  );
  modport slave (
    input  wr_en, wr_addr, wr_data, start, rd_addr,
    output rd_data, busy, done
  );
`endif
endinterface

// File: rtl/cmp_sort_ctrl.sv
// In-place ascending bubble sorter: one shared greater-than compare (and optional swap) per clock.
// Define SORT_STATS_EN to add saturating compare/swap counters (cmp_cnt, swap_cnt).
module cmp_sort_ctrl #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 4
) (
  input logic       clk,
  input logic       rst_n,
  cmp_sort_if.slave bus
);
  localparam int unsigned AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SORT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    j, j_nxt, pass, pass_nxt;
  logic             swapped, swapped_nxt;
  logic             busy_q, done_q, busy_nxt, done_nxt;

  logic [AW-1:0]    j1_c;
  logic [WIDTH-1:0] a_c, b_c;
  logic             gt_c, last_c, pass_last_c;
  logic             wr_ok_c, swap_c;

  // Shared comparator on the adjacent pair (j, j+1)
  assign j1_c        = j + AW'(1);
  assign a_c         = mem[j];
  assign b_c         = mem[j1_c];
  assign gt_c        = a_c > b_c;
  assign last_c      = (j == (AW'(DEPTH - 2) - pass));
  assign pass_last_c = (pass == AW'(DEPTH - 2));

  assign bus.rd_data = mem[bus.rd_addr];
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

  always_comb begin
    state_nxt   = state;
    j_nxt       = j;
    pass_nxt    = pass;
    swapped_nxt = swapped;
    wr_ok_c     = 1'b0;
    swap_c      = 1'b0;
    case (state)
      IDLE, DONE: begin
        wr_ok_c = bus.wr_en;
        if (bus.start) begin
          state_nxt   = SORT;
          j_nxt       = '0;
          pass_nxt    = '0;
          swapped_nxt = 1'b0;
        end else if (bus.wr_en) begin
          state_nxt = IDLE;
        end
      end
      SORT: begin
        swap_c = gt_c;
        if (last_c) begin
          // A clean pass, or the final pass, means the array is ordered
          if (!(swapped || gt_c) || pass_last_c) begin
            state_nxt = DONE;
          end else begin
            pass_nxt    = pass + AW'(1);
            j_nxt       = '0;
            swapped_nxt = 1'b0;
          end
        end else begin
          j_nxt       = j1_c;
          swapped_nxt = swapped | gt_c;
        end
      end
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt == SORT);
    done_nxt = (state_nxt == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      j       <= '0;
      pass    <= '0;
      swapped <= 1'b0;
    end else begin
      state   <= state_nxt;
      busy_q  <= busy_nxt;
      done_q  <= done_nxt;
      j       <= j_nxt;
      pass    <= pass_nxt;
      swapped <= swapped_nxt;
    end
  end

  // Register file: host writes outside SORT, pair swaps during SORT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (wr_ok_c) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end else if (swap_c) begin
      mem[j]    <= b_c;
      mem[j1_c] <= a_c;
    end
  end

`ifdef SORT_STATS_EN
  logic [7:0] cmp_q, swp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_q <= 8'd0;
      swp_q <= 8'd0;
    end else if (state != SORT && bus.start) begin
      cmp_q <= 8'd0;
      swp_q <= 8'd0;
    end else begin
      if (state == SORT && cmp_q != 8'hFF) cmp_q <= cmp_q + 8'd1;
      if (swap_c && swp_q != 8'hFF)        swp_q <= swp_q + 8'd1;
    end
  end

  assign bus.cmp_cnt  = cmp_q;
  assign bus.swap_cnt = swp_q;
`endif

endmodule
